// File: rtl/prt_pkg.sv
// Shared definitions for the packet reference table (PRT) slice: sizing
// constants, the ingress writer state encoding and the frame descriptor.
package prt_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned MAX_FRAME  = 1518;
  localparam int unsigned MIN_FRAME  = 64;
  localparam int unsigned NUM_SLOTS  = 2;
  localparam int unsigned SLOT_WIDTH = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned LEN_WIDTH  = $clog2(MAX_FRAME + 1);

  typedef enum logic [2:0] {
    ING_IDLE   = 3'd0,
    ING_START  = 3'd1,
    ING_SLOT   = 3'd2,
    ING_WRITE  = 3'd3,
    ING_DRAIN  = 3'd4,
    ING_FINISH = 3'd5,
    ING_DESC   = 3'd6
  } ing_state_e;

  typedef struct packed {
    logic [SLOT_WIDTH-1:0] slot;
    logic [LEN_WIDTH-1:0]  len;
    logic                  trunc;
    logic                  runt;
  } prt_desc_t;

endpackage

// File: rtl/prt_ingress_writer_if.sv
// Bundle of the ingress writer's three handshakes: RX byte stream, PRT
// write port and descriptor output.
//   master : the ingress writer
//   slave  : RX source, PRT and classifier side
interface prt_ingress_writer_if;
  import prt_pkg::*;

  logic [DATA_WIDTH-1:0] s_tdata;
  logic                  s_tvalid;
  logic                  s_tlast;
  logic                  s_tready;

  logic                  prt_slot_free;
  logic                  prt_start_en;
  logic                  prt_start_rdy;
  logic [SLOT_WIDTH-1:0] prt_start_slot;
  logic [DATA_WIDTH-1:0] prt_wr_data;
  logic                  prt_wr_en;
  logic                  prt_wr_rdy;
  logic                  prt_finish_en;
  logic                  prt_finish_rdy;

  logic                  desc_valid;
  logic                  desc_ready;
  logic [SLOT_WIDTH-1:0] desc_slot;
  logic [LEN_WIDTH-1:0]  desc_len;
  logic                  desc_trunc;
  logic                  desc_runt;

  modport master (
    input  s_tdata, s_tvalid, s_tlast,
    output s_tready,
    input  prt_slot_free, prt_start_rdy, prt_start_slot, prt_wr_rdy, prt_finish_rdy,
    output prt_start_en, prt_wr_data, prt_wr_en, prt_finish_en,
    input  desc_ready,
    output desc_valid, desc_slot, desc_len, desc_trunc, desc_runt
  );

  modport slave (
    output s_tdata, s_tvalid, s_tlast,
    input  s_tready,
    output prt_slot_free, prt_start_rdy, prt_start_slot, prt_wr_rdy, prt_finish_rdy,
    input  prt_start_en, prt_wr_data, prt_wr_en, prt_finish_en,
    output desc_ready,
    input  desc_valid, desc_slot, desc_len, desc_trunc, desc_runt
  );

endinterface

// File: rtl/prt_ingress_writer.sv
// PRT ingress writer: acquires a PRT slot per RX frame, streams the frame
// bytes into it (truncating at MAX_FRAME and draining the excess), closes
// the entry and presents one descriptor per frame.
// Ports:
//   CLK, RST_N  clock, asynchronous active-low reset
//   bus         master side of prt_ingress_writer_if (RX, PRT, descriptor)
//   cnt_frames  completed frames, wraps
//   cnt_trunc   truncated frames, wraps
module prt_ingress_writer
  import prt_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST_N,
  prt_ingress_writer_if.master bus,
  output logic [15:0]          cnt_frames,
  output logic [15:0]          cnt_trunc
);

  ing_state_e            state_q, state_d;
  logic [SLOT_WIDTH-1:0] slot_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic                  trunc_q;
  prt_desc_t             desc;

  logic wr_xfer;
  logic drain_xfer;
  logic at_max;

  assign wr_xfer    = (state_q == ING_WRITE) && bus.s_tvalid && bus.prt_wr_rdy;
  assign drain_xfer = (state_q == ING_DRAIN) && bus.s_tvalid;
  // The transfer in flight is the MAX_FRAME-th byte
  assign at_max     = (len_q == LEN_WIDTH'(MAX_FRAME - 1));

  assign desc.slot  = slot_q;
  assign desc.len   = len_q;
  assign desc.trunc = trunc_q;
  assign desc.runt  = (len_q < LEN_WIDTH'(MIN_FRAME));

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ING_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ING_IDLE:   if (bus.s_tvalid && bus.prt_slot_free) state_d = ING_START;
      ING_START:  if (bus.prt_start_rdy) state_d = ING_SLOT;
      ING_SLOT:   state_d = ING_WRITE;
      ING_WRITE: begin
        if (wr_xfer) begin
          if (bus.s_tlast)  state_d = ING_FINISH;
          else if (at_max)  state_d = ING_DRAIN;
        end
      end
      ING_DRAIN:  if (drain_xfer && bus.s_tlast) state_d = ING_FINISH;
      ING_FINISH: if (bus.prt_finish_rdy) state_d = ING_DESC;
      ING_DESC:   if (bus.desc_ready) state_d = ING_IDLE;
      default:    state_d = ING_IDLE;
    endcase
  end

  // Output decode; data path to the PRT is a zero-latency pass-through
  always_comb begin
    bus.s_tready      = 1'b0;
    bus.prt_start_en  = 1'b0;
    bus.prt_wr_en     = 1'b0;
    bus.prt_wr_data   = '0;
    bus.prt_finish_en = 1'b0;
    bus.desc_valid    = 1'b0;
    bus.desc_slot     = '0;
    bus.desc_len      = '0;
    bus.desc_trunc    = 1'b0;
    bus.desc_runt     = 1'b0;
    unique case (state_q)
      ING_START:  bus.prt_start_en = 1'b1;
      ING_WRITE: begin
        bus.s_tready    = bus.prt_wr_rdy;
        bus.prt_wr_en   = bus.s_tvalid && bus.prt_wr_rdy;
        bus.prt_wr_data = bus.s_tdata;
      end
      ING_DRAIN:  bus.s_tready = 1'b1;
      ING_FINISH: bus.prt_finish_en = 1'b1;
      ING_DESC: begin
        bus.desc_valid = 1'b1;
        bus.desc_slot  = desc.slot;
        bus.desc_len   = desc.len;
        bus.desc_trunc = desc.trunc;
        bus.desc_runt  = desc.runt;
      end
      default: ;
    endcase
  end

  // Per-frame slot, byte count and truncation flag
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      slot_q  <= '0;
      len_q   <= '0;
      trunc_q <= 1'b0;
    end else if (state_q == ING_SLOT) begin
      slot_q  <= bus.prt_start_slot;
      len_q   <= '0;
      trunc_q <= 1'b0;
    end else if (wr_xfer) begin
      len_q <= len_q + LEN_WIDTH'(1);
      if (!bus.s_tlast && at_max) trunc_q <= 1'b1;
    end
  end

  // Statistics, counted when the descriptor is consumed
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_frames <= '0;
      cnt_trunc  <= '0;
    end else if ((state_q == ING_DESC) && bus.desc_ready) begin
      cnt_frames <= cnt_frames + 16'd1;
      if (trunc_q) cnt_trunc <= cnt_trunc + 16'd1;
    end
  end

endmodule

// File: tb/tb_prt_ingress_writer.sv
// Self-checking bench for prt_ingress_writer: random frames, a behavioural
// PRT/classifier responder and a frame-level reference model.
module tb_prt_ingress_writer;
  import prt_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [15:0] cnt_frames;
  logic [15:0] cnt_trunc;

  always #5 CLK = ~CLK;

  prt_ingress_writer_if bus();

  prt_ingress_writer dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .bus        (bus.master),
    .cnt_frames (cnt_frames),
    .cnt_trunc  (cnt_trunc)
  );

  typedef struct {
    int len;
    bit trunc;
    bit runt;
  } exp_desc_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_bytes[$];
  exp_desc_t   exp_q[$];
  int          slot_q[$];
  logic [7:0]  wr_q[$];
  int          m_frames = 0;
  int          m_trunc = 0;
  bit          abort = 0;
  bit          desc_hold = 0;
  bit          wr_stall_en = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one frame of n random bytes; valid is dropped gap_pct% of cycles
  task automatic send_frame(input int n, input int gap_pct);
    logic [7:0] b[$];
    exp_desc_t  d;
    int         i;
    int         budget;
    bit         xfer;
    for (int k = 0; k < n; k++) b.push_back(8'($urandom));
    for (int k = 0; k < n && k < int'(MAX_FRAME); k++) exp_bytes.push_back(b[k]);
    d.len   = (n > int'(MAX_FRAME)) ? int'(MAX_FRAME) : n;
    d.trunc = (n > int'(MAX_FRAME));
    d.runt  = (d.len < int'(MIN_FRAME));
    exp_q.push_back(d);
    i = 0;
    budget = 0;
    while (i < n && !abort) begin
      bus.s_tvalid = ($urandom_range(99) >= gap_pct);
      bus.s_tdata  = b[i];
      bus.s_tlast  = (i == n - 1);
      @(negedge CLK);
      xfer = bus.s_tvalid && bus.s_tready;
      @(posedge CLK); #1;
      if (xfer) begin
        i++;
        budget = 0;
      end else begin
        budget++;
        if (budget > 4000) begin
          chk("tx_timeout", 32'(i), 32'(n));
          break;
        end
      end
    end
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
  endtask

  task automatic wait_desc();
    int b = 0;
    while (exp_q.size() != 0 && b < 8000) begin
      @(posedge CLK); #1;
      b++;
    end
    if (exp_q.size() != 0) chk("desc_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) begin
      @(posedge CLK); #1;
    end
  endtask

  // PRT and classifier responder: decides at negedge, drives after posedge
  initial begin
    int st_dly = 0;
    int fi_dly = 0;
    int slot_hold = 0;
    int alloc = 0;
    bit st_en, st_rdy, fi_en, fi_rdy;
    bus.prt_start_rdy  = 1'b0;
    bus.prt_start_slot = '0;
    bus.prt_wr_rdy     = 1'b0;
    bus.prt_finish_rdy = 1'b0;
    bus.desc_ready     = 1'b0;
    forever begin
      @(negedge CLK);
      st_en  = bus.prt_start_en;
      st_rdy = bus.prt_start_rdy;
      fi_en  = bus.prt_finish_en;
      fi_rdy = bus.prt_finish_rdy;
      @(posedge CLK); #1;
      if (!RST_N) begin
        alloc = 0;
        slot_hold = 0;
        bus.prt_start_rdy  = 1'b0;
        bus.prt_finish_rdy = 1'b0;
        bus.prt_wr_rdy     = 1'b0;
        bus.desc_ready     = 1'b0;
        continue;
      end
      bus.prt_start_rdy  = 1'b0;
      bus.prt_finish_rdy = 1'b0;
      // Slot index is only meaningful from the ack cycle through the next one
      if (slot_hold > 0) slot_hold--;
      else bus.prt_start_slot = SLOT_WIDTH'($urandom);
      if (st_en && !st_rdy) begin
        if (st_dly == 0) begin
          bus.prt_start_rdy  = 1'b1;
          bus.prt_start_slot = SLOT_WIDTH'(alloc);
          slot_q.push_back(alloc);
          alloc = (alloc + 1) % int'(NUM_SLOTS);
          slot_hold = 1;
          st_dly = $urandom_range(3);
        end else st_dly--;
      end
      if (fi_en && !fi_rdy) begin
        if (fi_dly == 0) begin
          bus.prt_finish_rdy = 1'b1;
          fi_dly = $urandom_range(3);
        end else fi_dly--;
      end
      bus.prt_wr_rdy = wr_stall_en ? ($urandom_range(3) != 0) : 1'b1;
      bus.desc_ready = desc_hold ? 1'b0 : ($urandom_range(1) == 1);
    end
  end

  // Monitor: collects PRT writes and checks every consumed descriptor
  initial begin
    exp_desc_t d;
    bit        ok;
    bit        pend = 0;
    int        exp_slot;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        exp_bytes.delete();
        exp_q.delete();
        slot_q.delete();
        wr_q.delete();
        m_frames = 0;
        m_trunc = 0;
        pend = 0;
        continue;
      end
      if (pend) begin
        chk("cnt_frames", 32'(cnt_frames), 32'(m_frames % 65536));
        chk("cnt_trunc", 32'(cnt_trunc), 32'(m_trunc % 65536));
        pend = 0;
      end
      if (bus.prt_start_en && bus.prt_finish_en) chk("start_finish_excl", 32'd1, 32'd0);
      if (bus.prt_wr_en) wr_q.push_back(bus.prt_wr_data);
      if (bus.desc_valid && bus.desc_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_desc", 32'd1, 32'd0);
        end else begin
          d = exp_q.pop_front();
          exp_slot = (slot_q.size() != 0) ? slot_q.pop_front() : -1;
          chk("desc_slot", 32'(bus.desc_slot), 32'(exp_slot));
          chk("desc_len", 32'(bus.desc_len), 32'(d.len));
          chk("desc_trunc", 32'(bus.desc_trunc), 32'(d.trunc));
          chk("desc_runt", 32'(bus.desc_runt), 32'(d.runt));
          chk("wr_count", 32'(wr_q.size()), 32'(d.len));
          ok = 1'b1;
          for (int k = 0; k < d.len; k++) begin
            if (wr_q.size() == 0 || exp_bytes.size() == 0) ok = 1'b0;
            else if (wr_q.pop_front() !== exp_bytes.pop_front()) ok = 1'b0;
          end
          chk("wr_bytes", 32'(ok), 32'd1);
          wr_q.delete();
          m_frames++;
          if (d.trunc) m_trunc++;
          pend = 1'b1;
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  // Main sequence
  initial begin
    bus.s_tvalid      = 1'b0;
    bus.s_tdata       = '0;
    bus.s_tlast       = 1'b0;
    bus.prt_slot_free = 1'b1;
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_tready", 32'(bus.s_tready), 32'd0);
    chk("rst_start_en", 32'(bus.prt_start_en), 32'd0);
    chk("rst_wr_en", 32'(bus.prt_wr_en), 32'd0);
    chk("rst_finish_en", 32'(bus.prt_finish_en), 32'd0);
    chk("rst_desc_valid", 32'(bus.desc_valid), 32'd0);
    chk("rst_desc_runt", 32'(bus.desc_runt), 32'd0);
    chk("rst_cnt_frames", 32'(cnt_frames), 32'd0);
    chk("rst_cnt_trunc", 32'(cnt_trunc), 32'd0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    send_frame(100, 0);
    wait_desc();
    chk("t100_frames", 32'(cnt_frames), 32'd1);

    send_frame(1600, 0);
    wait_desc();
    chk("t1600_trunc", 32'(cnt_trunc), 32'd1);

    send_frame(40, 10);
    send_frame(1, 0);
    wait_desc();

    // No free slot: nothing may move while the RX byte is waiting
    bus.prt_slot_free = 1'b0;
    fork
      send_frame(20, 0);
      begin
        bit ok = 1'b1;
        repeat (50) begin
          @(negedge CLK);
          if (bus.s_tready || bus.prt_start_en) ok = 1'b0;
        end
        chk("nofree_hold", 32'(ok), 32'd1);
        @(posedge CLK); #1;
        bus.prt_slot_free = 1'b1;
        repeat (2) @(negedge CLK);
        chk("free_start", 32'(bus.prt_start_en), 32'd1);
      end
    join
    wait_desc();

    // Descriptor backpressure with a second frame pending
    desc_hold = 1'b1;
    send_frame(80, 0);
    fork
      send_frame(90, 20);
      begin
        bit ok = 1'b1;
        int b = 0;
        logic [31:0] snap;
        while (!bus.desc_valid && b < 4000) begin
          @(negedge CLK);
          b++;
        end
        chk("hold_desc_valid", 32'(bus.desc_valid), 32'd1);
        snap = 32'({bus.desc_slot, bus.desc_len, bus.desc_trunc, bus.desc_runt});
        repeat (20) begin
          @(negedge CLK);
          if (32'({bus.desc_slot, bus.desc_len, bus.desc_trunc, bus.desc_runt}) !== snap ||
              !bus.desc_valid || bus.s_tready || bus.prt_start_en) ok = 1'b0;
        end
        chk("hold_stable", 32'(ok), 32'd1);
        desc_hold = 1'b0;
      end
    join
    wait_desc();

    send_frame(int'(MAX_FRAME), 0);
    send_frame(int'(MAX_FRAME) + 1, 0);
    wait_desc();

    wr_stall_en = 1'b1;
    repeat (6) send_frame(int'($urandom_range(1, 150)), 25);
    wait_desc();
    wr_stall_en = 1'b0;

    // Reset in the middle of a frame
    fork
      send_frame(120, 0);
      begin
        int n = 0;
        int b = 0;
        while (n < 30 && b < 4000) begin
          @(negedge CLK);
          if (bus.prt_wr_en) n++;
          b++;
        end
        chk("midrst_reached", 32'(n), 32'd30);
        @(posedge CLK); #2;
        RST_N = 1'b0;
        #1;
        chk("midrst_tready", 32'(bus.s_tready), 32'd0);
        chk("midrst_wr_en", 32'(bus.prt_wr_en), 32'd0);
        chk("midrst_start_en", 32'(bus.prt_start_en), 32'd0);
        chk("midrst_finish_en", 32'(bus.prt_finish_en), 32'd0);
        chk("midrst_desc_valid", 32'(bus.desc_valid), 32'd0);
        chk("midrst_cnt_frames", 32'(cnt_frames), 32'd0);
        abort = 1'b1;
      end
    join
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    abort = 1'b0;
    @(posedge CLK); #1;
    send_frame(70, 0);
    wait_desc();
    chk("post_rst_frames", 32'(cnt_frames), 32'd1);
    chk("post_rst_trunc", 32'(cnt_trunc), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prt_ingress_writer.md
Name: prt_ingress_writer

Overview:
Upstream stage of the packet reference table (PRT). It accepts a byte stream (valid/ready/last) from the Ethernet RX path and acquires a free PRT slot for each frame. It then pushes the frame bytes into that slot through the PRT write handshake and closes the entry. On completion it emits one descriptor {slot, length, flags} to the downstream classifier. Oversize frames are truncated and runt frames are flagged; no frame is ever silently lost.

Parameters:
DATA_WIDTH, 8, stream and PRT data width (one byte)
MAX_FRAME, 1518, maximum bytes written per frame; PRT slot depth must be >= MAX_FRAME
MIN_FRAME, 64, frames shorter than this are flagged runt
NUM_SLOTS, 2, PRT slot count
SLOT_WIDTH, $clog2(NUM_SLOTS), slot index width
LEN_WIDTH, $clog2(MAX_FRAME+1), length counter width

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous, active-low reset
s_tdata  in  DATA_WIDTH  RX byte
s_tvalid  in  1  RX byte valid
s_tlast  in  1  last byte of frame
s_tready  out  1  byte accepted when s_tvalid&&s_tready
prt_slot_free  in  1  PRT has a free slot
prt_start_en  out  1  request start of a PRT write
prt_start_rdy  in  1  PRT start acknowledge pulse
prt_start_slot  in  SLOT_WIDTH  slot allocated by PRT
prt_wr_data  out  DATA_WIDTH  byte to PRT
prt_wr_en  out  1  write strobe
prt_wr_rdy  in  1  PRT in data-write state
prt_finish_en  out  1  request entry close
prt_finish_rdy  in  1  PRT finish acknowledge pulse
desc_valid  out  1  descriptor valid
desc_ready  in  1  descriptor consumed
desc_slot  out  SLOT_WIDTH  slot holding frame
desc_len  out  LEN_WIDTH  bytes stored in PRT
desc_trunc  out  1  frame exceeded MAX_FRAME
desc_runt  out  1  desc_len < MIN_FRAME
cnt_frames  out  16  frames completed, wraps
cnt_trunc  out  16  truncated frames, wraps

Behaviour:
- Reset: state IDLE. All outputs 0, including s_tready, prt_*_en, desc_*, counters and the internal byte count.
- Reset mid-frame aborts the frame; the PRT is reset by the same RST_N.
- States: IDLE, START, SLOT, WRITE, DRAIN, FINISH, DESC.
- IDLE: s_tready=0. If s_tvalid && prt_slot_free, go to START. The first byte is held upstream and is not consumed.
- START: prt_start_en=1 (held). When prt_start_rdy, go to SLOT.
- SLOT: one cycle. Latch prt_start_slot into the slot register (PRT updates its slot index on leaving its start state). Clear byte count, trunc flag. Go to WRITE.
- WRITE:
  - s_tready=prt_wr_rdy; prt_wr_en=s_tvalid&&prt_wr_rdy; prt_wr_data=s_tdata (combinational pass-through, zero latency).
  - Each transfer increments the count.
  - Transfer with s_tlast: go to FINISH.
  - Transfer without s_tlast that makes count==MAX_FRAME: set trunc, go to DRAIN.
- DRAIN: s_tready=1, prt_wr_en=0. Bytes are discarded and the count does not change. Transfer with s_tlast goes to FINISH.
- FINISH: s_tready=0, prt_finish_en=1 (held). When prt_finish_rdy, go to DESC.
- DESC: desc_valid=1, with desc_slot/len/trunc/runt stable. When desc_ready:
  - cnt_frames+1, and cnt_trunc+1 if trunc.
  - Go to IDLE.
  - No new frame is accepted until the descriptor is taken (backpressure to RX).
- desc_len counts only bytes written to the PRT and saturates at MAX_FRAME. desc_runt = desc_len < MIN_FRAME.
- A 1-byte frame (s_tlast on the first beat) is valid: len=1, runt=1.
- s_tlast exactly on byte MAX_FRAME: trunc=0, no DRAIN.
- prt_slot_free low: the writer waits in IDLE indefinitely; s_tready stays 0.
- s_tvalid gaps in WRITE/DRAIN are allowed; there is no timeout.
- Enables are level-held until the matching rdy. The writer never issues start and finish in the same cycle.

Decomposition:
- Shared package prt_pkg:
  - ingress state enum
  - descriptor struct {slot, len, trunc, runt}
  - DATA_WIDTH, NUM_SLOTS, MAX_FRAME, MIN_FRAME constants, also used by the PRT and the downstream reader
- No sub-module: a single FSM plus counters.

Test Plan:
- 100-byte frame, slot 0 free: 100 prt_wr_en pulses with matching bytes, one finish, descriptor {slot0, len 100, trunc0, runt0}, cnt_frames=1.
- 1600-byte frame: 1518 bytes written, 82 drained with s_tready=1, descriptor {len 1518, trunc1}, cnt_trunc=1.
- 40-byte frame, then a 1-byte frame: descriptors len 40 runt1 and len 1 runt1; second frame uses the next free slot.
- prt_slot_free=0 with s_tvalid=1 for 50 cycles: s_tready=0 and prt_start_en=0 throughout; free rises, and start follows within 1 cycle.
- desc_ready held 0 for 20 cycles with a second frame pending: descriptor stable, s_tready=0; release gives the second frame normal handling.
- RST_N asserted mid-WRITE at byte 30: all outputs 0 immediately; the next frame after release completes correctly with len from its own bytes.
